multibyte_add_seq: RTL and testbench
====================================

# multibyte_add_seq

Sequential multi-byte adder that sits directly upstream and downstream of the team's 8-bit carry-lookahead adder. It streams NBYTES-wide operands through a single CLA one byte per cycle, least-significant byte first, and registers the CLA carry-out back into the next byte's carry-in. It reassembles the full-width sum and reports carry-out and signed overflow behind a start/busy/done handshake. This trades latency for area on wide additions.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2..16; W = 8*NBYTES.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; sampled on the accepting edge only.
- b  input  W  operand B; sampled on the accepting edge only.
- cin  input  1  carry into byte 0; sampled on the accepting edge only.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  single-cycle pulse; result valid.
- sum  output  W  registered result; holds until the next result.
- cout  output  1  carry out of the MSB byte.
- ovf  output  1  two's-complement overflow of the W-bit add.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE: if start=1 on an edge, the block loads the a/b shift registers, sets carry_q=cin, sets idx=0 and moves to RUN. If start=0, it stays in IDLE.
- RUN, on each edge:
  - Byte a_sh[7:0] + b_sh[7:0] + carry_q goes through the CLA.
  - The CLA sum byte shifts into the top of res_sh, and res_sh shifts right by 8.
  - a_sh and b_sh shift right by 8.
  - carry_q is loaded with the CLA cout, and idx increments.
  - On the edge where idx==NBYTES-1, the block moves to DONE.
- On the RUN to DONE edge:
  - sum is loaded with the final res_sh, including the last byte.
  - cout is loaded with the final CLA cout.
  - ovf is loaded with (a_msb==b_msb) && (sum_msb!=a_msb), using the MSBs of the original operands.
- DONE: done=1 for this single cycle, and the next edge returns the FSM to IDLE unconditionally.
- start in RUN or DONE is ignored. It is not queued, and it has no effect on the in-flight operation.
- sum, cout and ovf change only on the RUN to DONE edge or on reset. They are never partially updated mid-operation.
- Arithmetic is modulo 2^W. cout is bit W of a+b+cin.
- Reset, asserted at any time including mid-RUN:
  - The FSM returns to IDLE immediately, without waiting for a clock edge.
  - busy, done, sum, cout, ovf, idx and carry_q all go to 0.
  - The in-flight operation is discarded.

## Timing
- The accepting edge is E0.
- busy rises after E0 and falls after edge E0+NBYTES+1.
- The RUN to DONE transition occurs on edge E0+NBYTES.
- done is high during the single cycle between E0+NBYTES and E0+NBYTES+1. sum, cout and ovf are valid from that cycle onward.
- Latency from start to done is NBYTES+1 edges. Minimum start-to-start period is NBYTES+2 cycles, because IDLE is re-entered before the next accept.
- The critical path is one 8-bit CLA plus the carry_q register. There is no combinational path from any input to any output.
- Outputs after reset deassertion: all 0. The first start is accepted on the first edge after rst falls.

## Structure
- Shared package add_pkg:
  - state enum state_t {IDLE, RUN, DONE}, encoded 2 bits.
  - Constant BYTE_W = 8.
  - Function ovf_calc(a_msb, b_msb, s_msb).
- Sub-module: exactly one instance of carry_lookahead_adder_8bit as the byte datapath. No other adder logic is permitted in the block.
- idx width is $clog2(NBYTES).
- a_sh, b_sh and res_sh are W-bit shift registers.

## Test plan
All cases use NBYTES=4.
- Carry across a byte boundary: a=0x000000FF, b=0x00000001, cin=0 -> done after E0+4, sum=0x00000100, cout=0, ovf=0, busy high for exactly 5 cycles.
- Full ripple through every byte: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Negative overflow: a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Start while busy: accept a=0x12345678, b=0x11111111. Pulse start with a=0xFFFFFFFF at E0+2 -> sum=0x23456789, and exactly one done pulse.
- Reset mid-operation: assert rst asynchronously between E0+2 and E0+3 -> busy=0 and sum=0 with no clock edge. After release, a=5, b=7 -> sum=0x0000000C.
- Back-to-back: hold start=1 with randomized operands for 1000 operations -> accepts are exactly 6 cycles apart, and every sum/cout matches a 33-bit reference add.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and helpers for the multi-byte sequential adder
//
// Purpose: FSM state type, byte width constant and the signed-overflow rule
//          used by multibyte_add_seq.
// Exports: state_t (IDLE/RUN/DONE, 2-bit), BYTE_W, ovf_calc().
package add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_8bit.sv
// rtl/carry_lookahead_adder_8bit.sv - 8-bit carry-lookahead adder, byte datapath
//
// Purpose: sum = a + b + cin over one byte, carries from two 4-bit lookahead groups.
// Ports:   a, b  [7:0] in  operand bytes
//          cin         in  carry in
//          sum   [7:0] out sum byte
//          cout        out carry out of bit 7
module carry_lookahead_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [4:0] c_lo;
  logic [4:0] c_hi;
  logic [7:0] c;

  // Flattened lookahead carries for a 4-bit group; bit 0 echoes the group carry in.
  function automatic logic [4:0] cla4(input logic [3:0] gi, input logic [3:0] pi, input logic c0);
    logic [4:0] cc;
    cc[0] = c0;
    cc[1] = gi[0] | (pi[0] & c0);
    cc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
    cc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & c0);
    cc[4] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0])
          | (pi[3] & pi[2] & pi[1] & pi[0] & c0);
    return cc;
  endfunction

  assign g    = a & b;
  assign p    = a ^ b;
  assign c_lo = cla4(g[3:0], p[3:0], cin);
  assign c_hi = cla4(g[7:4], p[7:4], c_lo[4]);
  assign c    = {c_hi[3:0], c_lo[3:0]};
  assign sum  = p ^ c;
  assign cout = c_hi[4];

endmodule

// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - sequential W-bit adder, one byte per cycle through one CLA
//
// Purpose: accepts a/b/cin on start in IDLE, adds LSB byte first over NBYTES
//          cycles, then presents sum/cout/ovf with a one-cycle done pulse.
// Ports:   clk, rst (async, active high)
//          start       in  request, sampled only in IDLE
//          a, b  [W-1:0] in operands, cin in carry into byte 0
//          busy        out state != IDLE
//          done        out single-cycle result-valid pulse
//          sum [W-1:0], cout, ovf  out registered result, held until next result
module multibyte_add_seq
  import add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [W-1:0]     a_sh_q,   a_sh_d;
  logic [W-1:0]     b_sh_q,   b_sh_d;
  logic [W-1:0]     res_sh_q, res_sh_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic [W-1:0]     sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic [7:0]       cla_sum;
  logic             cla_cout;

  carry_lookahead_adder_8bit u_cla (
    .a    (a_sh_q[BYTE_W-1:0]),
    .b    (b_sh_q[BYTE_W-1:0]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          idx_d    = '0;
          res_sh_d = '0;
          // Operand sign bits are shifted out during RUN, so keep copies for ovf.
          a_msb_d  = a[W-1];
          b_msb_d  = b[W-1];
          state_d  = RUN;
        end
      end

      RUN: begin
        res_sh_d = {cla_sum, res_sh_q[W-1:BYTE_W]};
        a_sh_d   = a_sh_q >> BYTE_W;
        b_sh_d   = b_sh_q >> BYTE_W;
        carry_d  = cla_cout;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Publish from the next-state shift value so the last byte is included.
          sum_d   = res_sh_d;
          cout_d  = cla_cout;
          ovf_d   = ovf_calc(a_msb_q, b_msb_q, cla_sum[BYTE_W-1]);
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - self-checking bench for multibyte_add_seq (NBYTES=4)
module tb_multibyte_add_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int vectors;
  int miscompares;

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic plus the sign rule, packed {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    v    = (x[31] == y[31]) && (full[31] != x[31]);
    return {v, full};
  endfunction

  // One operation: start is high for the accepting edge only; optional second start pulse
  // on edge E0+pulse_edge. Samples at each negedge k=0..11 after E0.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input int pulse_edge,
                       output int done_k, output int busy_cycles, output int done_pulses,
                       output logic [33:0] got);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_k = -1; busy_cycles = 0; done_pulses = 0; got = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_k < 0) begin
          done_k = k;
          got = {ovf, cout, sum};
        end
      end
      if (pulse_edge >= 0 && k == pulse_edge - 1) begin
        a = 32'hFFFF_FFFF; start = 1'b1;
      end
      if (pulse_edge >= 0 && k == pulse_edge) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #3;
    vectors++;
    if ({busy, done, sum, cout, ovf} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc, input logic [33:0] want);
    int dk, bc, dp;
    logic [33:0] got;
    do_op(ta, tb, tc, -1, dk, bc, dp, got);
    vectors++;
    if (got !== want || dk != 4 || dp != 1) begin
      miscompares++;
      $display("FAIL %s got ovf/cout/sum=%h done_k=%0d pulses=%0d want %h done_k=4 pulses=1",
               name, got, dk, dp, want);
    end
  endtask

  task automatic test_carry_boundary;
    int dk, bc, dp;
    logic [33:0] got;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, -1, dk, bc, dp, got);
    vectors++;
    if (got !== {1'b0, 1'b0, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL carry_boundary_result got %h want %h", got, {2'b00, 32'h0000_0100});
    end
    vectors++;
    if (dk != 4) begin
      miscompares++;
      $display("FAIL carry_boundary_done_edge got E0+%0d want E0+4", dk);
    end
    vectors++;
    if (bc != 5) begin
      miscompares++;
      $display("FAIL carry_boundary_busy_cycles got %0d want 5", bc);
    end
  endtask

  task automatic test_full_ripple;
    check_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 1'b1, 32'h0});
  endtask

  task automatic test_overflow;
    check_op("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    check_op("neg_overflow", 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0});
    check_op("mixed_sign", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, {1'b0, 1'b1, 32'h0});
  endtask

  task automatic test_start_while_busy;
    int dk, bc, dp;
    logic [33:0] got;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 2, dk, bc, dp, got);
    vectors++;
    if (got[31:0] !== 32'h2345_6789) begin
      miscompares++;
      $display("FAIL busy_start_sum got %h want 23456789", got[31:0]);
    end
    vectors++;
    if (dp != 1 || bc != 5) begin
      miscompares++;
      $display("FAIL busy_start_pulses got done=%0d busy=%0d want done=1 busy=5", dp, bc);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || sum !== 32'd0 || done !== 1'b0 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got busy=%b sum=%h done=%b cout=%b want 0", busy, sum, done, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("after_reset", 32'd5, 32'd7, 1'b0, {2'b00, 32'h0000_000C});
  endtask

  task automatic test_back_to_back;
    logic [33:0] exp_q[$];
    logic [33:0] want;
    int accepts, cyc, last_acc, budget;
    logic prev_busy;
    @(negedge clk);
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); start = 1'b1;
    accepts = 0; cyc = 0; last_acc = -1; prev_busy = busy; budget = 0;
    while ((accepts < 1000 || exp_q.size() != 0) && budget < 7000) begin
      @(posedge clk);
      #1;
      cyc++; budget++;
      if (busy && !prev_busy) begin
        exp_q.push_back(ref_add(a, b, cin));
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc != 6) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d want 6 at accept %0d", cyc - last_acc, accepts);
          end
        end
        last_acc = cyc;
        accepts++;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        if (accepts >= 1000) start = 1'b0;
      end
      if (done) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra_done got unexpected done want none");
        end else begin
          want = exp_q.pop_front();
          if ({ovf, cout, sum} !== want) begin
            miscompares++;
            $display("FAIL b2b_result got %h want %h", {ovf, cout, sum}, want);
          end
        end
      end
      prev_busy = busy;
    end
    start = 1'b0;
    vectors++;
    if (accepts != 1000 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_timeout got accepts=%0d pending=%0d want 1000 0", accepts, exp_q.size());
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_carry_boundary();
    test_full_ripple();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
